// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with stall/flush and saturating illegal counter
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [31:0]      inst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             clr_cnt_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);
  localparam int SH = (XLEN == 64) ? 6 : 5;
  logic [2:0]                    f3;
  logic [XLEN-1:0]               imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [XLEN-1:0]               dec_imm;
  logic [2:0]                    dec_fmt;
  logic                          dec_ill;
  logic [STAGES-1:0]             v_q, v_d, ill_q, ill_d;
  logic [STAGES-1:0][XLEN-1:0]   imm_q, imm_d;
  logic [STAGES-1:0][2:0]        fmt_q, fmt_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          inc;
  assign f3     = inst_i[14:12];
  assign imm_i  = XLEN'($signed(inst_i[31:20]));
  assign imm_s  = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b  = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign imm_sh = XLEN'(inst_i[20 +: SH]);
  // opcode decode into immediate, format code and illegal flag
  always_comb begin
    dec_imm = '0;
    dec_fmt = 3'd7;
    dec_ill = 1'b0;
    case (inst_i[6:0])
      7'b0010011: begin
        dec_fmt = (f3 == 3'b001 || f3 == 3'b101) ? 3'd6 : 3'd1;
        dec_imm = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin dec_fmt = 3'd1; dec_imm = imm_i; end
      7'b0100011: begin dec_fmt = 3'd2; dec_imm = imm_s; end
      7'b1100011: begin dec_fmt = 3'd3; dec_imm = imm_b; end
      7'b0110111, 7'b0010111: begin dec_fmt = 3'd4; dec_imm = imm_u; end
      7'b1101111: begin dec_fmt = 3'd5; dec_imm = imm_j; end
      7'b0110011: dec_fmt = 3'd0;
      default: dec_ill = 1'b1;
    endcase
  end
  // stage advance: flush clears, stall holds, otherwise shift with bubble on invalid input
  always_comb begin
    v_d   = v_q;
    imm_d = imm_q;
    fmt_d = fmt_q;
    ill_d = ill_q;
    if (flush_i) begin
      v_d   = '0;
      imm_d = '0;
      fmt_d = '0;
      ill_d = '0;
    end else if (!stall_i) begin
      v_d[0]   = valid_i;
      imm_d[0] = valid_i ? dec_imm : '0;
      fmt_d[0] = valid_i ? dec_fmt : 3'd0;
      ill_d[0] = valid_i & dec_ill;
      for (int i = 1; i < STAGES; i++) begin
        v_d[i]   = v_q[i-1];
        imm_d[i] = imm_q[i-1];
        fmt_d[i] = fmt_q[i-1];
        ill_d[i] = ill_q[i-1];
      end
    end
  end
  // count valid illegal entries entering the last stage; clear wins, saturate at all-ones
  always_comb begin
    inc   = !flush_i && !stall_i && v_d[STAGES-1] && ill_d[STAGES-1];
    cnt_d = clr_cnt_i ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q   <= '0;
      imm_q <= '0;
      fmt_q <= '0;
      ill_q <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      imm_q <= imm_d;
      fmt_q <= fmt_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end
  assign valid_o       = v_q[STAGES-1];
  assign imm_o         = imm_q[STAGES-1];
  assign fmt_o         = fmt_q[STAGES-1];
  assign illegal_o     = ill_q[STAGES-1];
  assign illegal_cnt_o = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe in three parameter configurations
module tb_imm_gen_pipe;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        clr_cnt_i = 1'b0;
  logic        a_v, b_v, c_v, a_ill, b_ill, c_ill;
  logic [31:0] a_imm, c_imm;
  logic [63:0] b_imm;
  logic [2:0]  a_fmt, b_fmt, c_fmt;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt, c_cnt;
  int checks = 0;
  int failures = 0;
  imm_gen_pipe #(.XLEN(32), .STAGES(1), .CNT_W(4)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .inst_i(inst_i), .stall_i(stall_i),
    .flush_i(flush_i), .clr_cnt_i(clr_cnt_i), .valid_o(a_v), .imm_o(a_imm), .fmt_o(a_fmt),
    .illegal_o(a_ill), .illegal_cnt_o(a_cnt));
  imm_gen_pipe #(.XLEN(64), .STAGES(1), .CNT_W(16)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .inst_i(inst_i), .stall_i(stall_i),
    .flush_i(flush_i), .clr_cnt_i(clr_cnt_i), .valid_o(b_v), .imm_o(b_imm), .fmt_o(b_fmt),
    .illegal_o(b_ill), .illegal_cnt_o(b_cnt));
  imm_gen_pipe #(.XLEN(32), .STAGES(2), .CNT_W(16)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .inst_i(inst_i), .stall_i(stall_i),
    .flush_i(flush_i), .clr_cnt_i(clr_cnt_i), .valid_o(c_v), .imm_o(c_imm), .fmt_o(c_fmt),
    .illegal_o(c_ill), .illegal_cnt_o(c_cnt));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins);
    valid_i = v;
    inst_i  = ins;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    chk("rst_a_valid", a_v, 0);
    chk("rst_a_imm", a_imm, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_c_valid", c_v, 0);
    rst_i = 1'b0;
    drive(1, 32'hFFF00093);
    tick();
    chk("addi_a_valid", a_v, 1);
    chk("addi_a_imm", a_imm, 32'hFFFFFFFF);
    chk("addi_a_fmt", a_fmt, 1);
    chk("addi_b_imm", b_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_c_lat", c_v, 0);
    drive(1, 32'h4030D093);
    tick();
    chk("srai_a_imm", a_imm, 32'h3);
    chk("srai_a_fmt", a_fmt, 6);
    chk("srai_b_imm", b_imm, 64'h3);
    chk("c_addi_valid", c_v, 1);
    chk("c_addi_imm", c_imm, 32'hFFFFFFFF);
    chk("c_addi_fmt", c_fmt, 1);
    drive(1, 32'hFE000EE3);
    tick();
    chk("beq_a_imm", a_imm, 32'hFFFFFFFC);
    chk("beq_a_fmt", a_fmt, 3);
    chk("c_srai_imm", c_imm, 32'h3);
    chk("c_srai_fmt", c_fmt, 6);
    drive(1, 32'h0080006F);
    tick();
    chk("jal_a_imm", a_imm, 32'h8);
    chk("jal_a_fmt", a_fmt, 5);
    drive(1, 32'hFE112E23);
    tick();
    chk("sw_a_imm", a_imm, 32'hFFFFFFFC);
    chk("sw_a_fmt", a_fmt, 2);
    drive(1, 32'h002081B3);
    tick();
    chk("add_a_imm", a_imm, 0);
    chk("add_a_fmt", a_fmt, 0);
    chk("add_a_ill", a_ill, 0);
    drive(1, 32'h123452B7);
    tick();
    chk("lui_b_imm", b_imm, 64'h0000000012345000);
    chk("lui_b_fmt", b_fmt, 4);
    drive(1, 32'h80000037);
    tick();
    chk("lui_neg_b_imm", b_imm, 64'hFFFFFFFF80000000);
    chk("lui_neg_a_imm", a_imm, 32'h80000000);
    drive(0, 32'h0);
    tick();
    chk("bubble_a_valid", a_v, 0);
    chk("bubble_a_imm", a_imm, 0);
    drive(1, 32'hFFF00093);
    tick();
    drive(1, 32'h4030D093);
    tick();
    drive(0, 32'h0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_c_valid", c_v, 1);
      chk("stall_c_imm", c_imm, 32'hFFFFFFFF);
      chk("stall_c_fmt", c_fmt, 1);
    end
    stall_i = 1'b0;
    tick();
    chk("resume_c_imm", c_imm, 32'h3);
    chk("resume_c_fmt", c_fmt, 6);
    chk("resume_c_valid", c_v, 1);
    tick();
    chk("drain_c_valid", c_v, 0);
    drive(1, 32'hFFF00093);
    tick();
    drive(1, 32'h4030D093);
    tick();
    drive(1, 32'hFE000EE3);
    stall_i = 1'b1;
    flush_i = 1'b1;
    tick();
    chk("flush_c_valid", c_v, 0);
    chk("flush_c_imm", c_imm, 0);
    chk("flush_a_valid", a_v, 0);
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(0, 32'h0);
    tick();
    chk("flush_lost_c_valid", c_v, 0);
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    chk("cnt_clr0", a_cnt, 0);
    drive(1, 32'hFFFFFFFF);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("ill_a_ill", a_ill, 1);
      chk("ill_a_fmt", a_fmt, 7);
      chk("ill_a_imm", a_imm, 0);
      chk("ill_a_cnt", a_cnt, (i > 15) ? 15 : i);
    end
    chk("ill_b_cnt", b_cnt, 20);
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    chk("cnt_clr_prio", a_cnt, 0);
    tick();
    chk("cnt_after_clr", a_cnt, 1);
    drive(1, 32'hFFF00093);
    tick();
    drive(1, 32'h4030D093);
    tick();
    chk("pre_rst_c_valid", c_v, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_c_valid", c_v, 0);
    chk("arst_c_imm", c_imm, 0);
    chk("arst_a_cnt", a_cnt, 0);
    chk("arst_a_valid", a_v, 0);
    drive(0, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("post_rst_c_valid", c_v, 0);
    tick();
    chk("post_rst2_c_valid", c_v, 0);
    chk("post_rst2_c_imm", c_imm, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
